// File: rtl/serial_subtractor_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package serial_sub_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/result bundle for the bit-serial subtractor.
interface serial_subtractor_if #(
    parameter int unsigned WIDTH = serial_sub_pkg::DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout
    );
endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// Combinational 1-bit full subtractor cell: d = a - b - bin.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    // Difference bit and borrow-out of a single bit position.
    always_comb begin
        d    = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: diff = a - b - bin over WIDTH cycles.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_subtractor_if.slave  bus
);

    // Bit-position counter width is derived from WIDTH, not overridable.
    localparam int unsigned CNT_W = $clog2(WIDTH);

    state_t             state;
    state_t             state_next;
    logic               load;
    logic               step;
    logic               last;

    logic [WIDTH-1:0]   a_sr;
    logic [WIDTH-1:0]   b_sr;
    // Only WIDTH-1 collected bits are stored; the final bit goes straight to diff.
    logic [WIDTH-2:0]   res_sr;
    logic [WIDTH-1:0]   res_next;
    logic               br;
    logic [CNT_W-1:0]   cnt;

    logic               d_bit;
    logic               br_next;
    logic [WIDTH-1:0]   diff_q;
    logic               bout_q;

    full_subtractor u_cell (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (br),
        .d    (d_bit),
        .bout (br_next)
    );

    assign res_next = {d_bit, res_sr};
    assign bus.diff = diff_q;
    assign bus.bout = bout_q;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        last       = 1'b0;
        bus.busy   = 1'b0;
        bus.done   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    load       = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                bus.busy = 1'b1;
                step     = 1'b1;
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    last       = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                bus.done   = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand shift registers, borrow flop, counter and held result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            diff_q <= '0;
            bout_q <= 1'b0;
        end else if (load) begin
            a_sr   <= bus.a;
            b_sr   <= bus.b;
            res_sr <= '0;
            br     <= bus.bin;
            cnt    <= '0;
        end else if (step) begin
            a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
            b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
            res_sr <= res_next[WIDTH-1:1];
            br     <= br_next;
            cnt    <= cnt + 1'b1;
            if (last) begin
                diff_q <= res_next;
                bout_q <= br_next;
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8).
module tb_serial_subtractor;

    localparam int unsigned W = 8;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    logic [W-1:0] last_diff;
    logic         last_bout;

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer subtraction.
    function automatic logic [W:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        int unsigned ua;
        int unsigned ub;
        int          d;
        logic [W-1:0] r;
        logic         bo;
        ua = int'(a);
        ub = int'(b) + int'(bin);
        bo = (ua < ub);
        d  = int'(a) - int'(b) - int'(bin);
        r  = W'(d);
        return {bo, r};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full operation with inputs scrambled and start poked while busy.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin, input bit rnd);
        logic [W:0] exp;
        exp = ref_sub(a, b, bin);
        bus.a     = a;
        bus.b     = b;
        bus.bin   = bin;
        bus.start = 1'b1;
        tick();
        chk("busy_after_accept", bus.busy, 1);
        chk("done_after_accept", bus.done, 0);
        for (int i = 1; i <= int'(W); i++) begin
            if (rnd) begin
                bus.a     = W'($urandom);
                bus.b     = W'($urandom);
                bus.bin   = 1'($urandom);
                bus.start = 1'($urandom);
            end else begin
                bus.start = 1'b0;
            end
            if (i == 3) begin
                bus.start = 1'b1;
                bus.a     = 8'hFF;
            end
            tick();
            if (i < int'(W)) begin
                chk("busy_mid", bus.busy, 1);
                chk("done_mid", bus.done, 0);
                chk("diff_held_mid", bus.diff, last_diff);
                chk("bout_held_mid", bus.bout, last_bout);
            end else begin
                chk("busy_in_done", bus.busy, 0);
                chk("done_pulse", bus.done, 1);
                chk("diff_result", bus.diff, exp[W-1:0]);
                chk("bout_result", bus.bout, exp[W]);
            end
        end
        if (rnd) bus.start = 1'($urandom);
        tick();
        chk("done_single", bus.done, 0);
        chk("busy_after_done", bus.busy, 0);
        chk("diff_hold_after", bus.diff, exp[W-1:0]);
        bus.start = 1'b0;
        last_diff = exp[W-1:0];
        last_bout = exp[W];
    endtask

    initial begin
        int last_done_cyc;
        int pulses;
        n_tests   = 0;
        n_fail    = 0;
        last_diff = '0;
        last_bout = 1'b0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.bin   = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_diff", bus.diff, 0);
        chk("rst_bout", bus.bout, 0);
        rst_n = 1'b1;
        tick();

        // 05 - 03
        do_op(8'h05, 8'h03, 1'b0, 1'b0);
        chk("tp1_diff", bus.diff, 8'h02);
        chk("tp1_bout", bus.bout, 0);

        // 03 - 05 wraps with borrow, then held through idle cycles
        do_op(8'h03, 8'h05, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("tp2_hold_diff", bus.diff, 8'hFE);
            chk("tp2_hold_bout", bus.bout, 1);
            chk("tp2_idle_busy", bus.busy, 0);
            chk("tp2_idle_done", bus.done, 0);
        end

        // 00 - 00 - 1: borrow ripples through every bit
        do_op(8'h00, 8'h00, 1'b1, 1'b0);
        chk("tp3_diff", bus.diff, 8'hFF);
        chk("tp3_bout", bus.bout, 1);

        // A5 - A5 with a start poke (a=FF) at k+3 inside do_op
        do_op(8'hA5, 8'hA5, 1'b0, 1'b0);
        chk("tp4_diff", bus.diff, 8'h00);
        chk("tp4_bout", bus.bout, 0);

        // Reset mid-operation aborts
        bus.a     = 8'h80;
        bus.b     = 8'h01;
        bus.bin   = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_diff", bus.diff, 0);
        chk("abort_bout", bus.bout, 0);
        last_diff = '0;
        last_bout = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("abort_no_done", bus.done, 0);
        end
        do_op(8'h10, 8'h01, 1'b0, 1'b0);
        chk("tp5_diff", bus.diff, 8'h0F);
        chk("tp5_bout", bus.bout, 0);

        // start held high: back-to-back ops every WIDTH+2 cycles
        bus.a         = 8'hFF;
        bus.b         = 8'h01;
        bus.bin       = 1'b1;
        bus.start     = 1'b1;
        last_done_cyc = -1;
        pulses        = 0;
        for (int cyc = 0; cyc < 60 && pulses < 3; cyc++) begin
            tick();
            chk("b2b_not_both", bus.busy & bus.done, 0);
            if (bus.done) begin
                chk("b2b_diff", bus.diff, 8'hFD);
                chk("b2b_bout", bus.bout, 0);
                chk("b2b_busy_low", bus.busy, 0);
                if (last_done_cyc >= 0) chk("b2b_period", cyc - last_done_cyc, 10);
                last_done_cyc = cyc;
                pulses++;
            end
        end
        chk("b2b_pulse_count", pulses, 3);
        bus.start = 1'b0;
        tick();
        tick();
        last_diff = 8'hFD;
        last_bout = 1'b0;

        // Randomized operations against the reference
        for (int n = 0; n < 20; n++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom), 1'b1);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
